// File: rtl/rggen_host_if_apb_if.sv
// Bus bundle between the APB master / register block array and the APB host front-end.
// Signals keep the front-end's point of view: i_* flow into it, o_* flow out of it.
//   slave  : view taken by rggen_host_if_apb
//   master : view taken by whatever drives APB and returns register responses
interface rggen_host_if_apb_if #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   // APB3 side
   logic                     i_psel;
   logic                     i_penable;
   logic [ADDRESS_WIDTH-1:0] i_paddr;
   logic                     i_pwrite;
   logic [DATA_WIDTH-1:0]    i_pwdata;
   logic [STRB_WIDTH-1:0]    i_pstrb;
   logic                     o_pready;
   logic [DATA_WIDTH-1:0]    o_prdata;
   logic                     o_pslverr;

   // Register request / response side
   logic                     o_req_valid;
   logic                     o_req_write;
   logic [ADDRESS_WIDTH-1:0] o_req_addr;
   logic [DATA_WIDTH-1:0]    o_req_wdata;
   logic [DATA_WIDTH-1:0]    o_req_wmask;
   logic                     i_resp_valid;
   logic                     i_resp_error;
   logic [DATA_WIDTH-1:0]    i_resp_rdata;

   modport slave (
      input  i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
      output o_pready, o_prdata, o_pslverr,
      output o_req_valid, o_req_write, o_req_addr, o_req_wdata, o_req_wmask,
      input  i_resp_valid, i_resp_error, i_resp_rdata
   );

   modport master (
      output i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
      input  o_pready, o_prdata, o_pslverr,
      input  o_req_valid, o_req_write, o_req_addr, o_req_wdata, o_req_wmask,
      output i_resp_valid, i_resp_error, i_resp_rdata
   );
endinterface

// File: rtl/rggen_host_if_apb.sv
// APB3 slave front-end for the generated register blocks. Each APB transfer becomes one
// register request; the block's response (or a timeout / misalignment error) is returned
// on the APB bus with a single-cycle pready.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : rggen_host_if_apb_if.slave (APB3 signals plus register request/response)
module rggen_host_if_apb #(
   parameter int unsigned ADDRESS_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   rggen_host_if_apb_if.slave         bus
);
   localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(STRB_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                   state_q,     state_d;
   logic [CNT_WIDTH-1:0]     cnt_q,       cnt_d;
   logic                     req_valid_q, req_valid_d;
   logic                     req_write_q, req_write_d;
   logic [ADDRESS_WIDTH-1:0] req_addr_q,  req_addr_d;
   logic [DATA_WIDTH-1:0]    req_wdata_q, req_wdata_d;
   logic [DATA_WIDTH-1:0]    req_wmask_q, req_wmask_d;
   logic                     pready_q,    pready_d;
   logic [DATA_WIDTH-1:0]    prdata_q,    prdata_d;
   logic                     pslverr_q,   pslverr_d;

   logic                     setup;
   logic                     misaligned;
   logic                     timeout_hit;
   logic [DATA_WIDTH-1:0]    wmask_exp;

   // Byte strobes expanded to a bit mask; reads never write anything
   always_comb begin
      wmask_exp = '0;
      for (int k = 0; k < int'(STRB_WIDTH); k++) begin
         wmask_exp[8*k +: 8] = {8{bus.i_pwrite & bus.i_pstrb[k]}};
      end
   end

   assign setup       = bus.i_psel && !bus.i_penable;
   assign misaligned  = |(bus.i_paddr & ALIGN_MASK);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_WIDTH'(TIMEOUT_LAST));

   // Next-state and next-output logic; APB result fields are non-zero only in DONE
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_valid_d = req_valid_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wmask_d = req_wmask_q;
      pready_d    = 1'b0;
      prdata_d    = '0;
      pslverr_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (setup) begin
               req_write_d = bus.i_pwrite;
               req_addr_d  = bus.i_paddr;
               req_wdata_d = bus.i_pwdata;
               req_wmask_d = wmask_exp;
               cnt_d       = '0;
               if (misaligned) begin
                  state_d   = DONE;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else begin
                  state_d     = REQ;
                  req_valid_d = 1'b1;
               end
            end
         end
         REQ: begin
            // A response in the final timeout cycle takes priority over the timeout
            if (bus.i_resp_valid) begin
               state_d     = DONE;
               req_valid_d = 1'b0;
               pready_d    = 1'b1;
               pslverr_d   = bus.i_resp_error;
               prdata_d    = req_write_q ? '0 : bus.i_resp_rdata;
            end else if (timeout_hit) begin
               state_d     = DONE;
               req_valid_d = 1'b0;
               pready_d    = 1'b1;
               pslverr_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_valid_q <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= '0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_valid_q <= req_valid_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wmask_q <= req_wmask_d;
         pready_q    <= pready_d;
         prdata_q    <= prdata_d;
         pslverr_q   <= pslverr_d;
      end
   end

   assign bus.o_pready    = pready_q;
   assign bus.o_prdata    = prdata_q;
   assign bus.o_pslverr   = pslverr_q;
   assign bus.o_req_valid = req_valid_q;
   assign bus.o_req_write = req_write_q;
   assign bus.o_req_addr  = req_addr_q;
   assign bus.o_req_wdata = req_wdata_q;
   assign bus.o_req_wmask = req_wmask_q;
endmodule

// File: tb/tb_rggen_host_if_apb.sv
module tb_rggen_host_if_apb;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;
   localparam int unsigned TMO = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   rggen_host_if_apb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

   rggen_host_if_apb #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   // Observed (or expected) outcome of one APB transfer
   typedef struct {
      int            reqc;    // cycles o_req_valid was high
      int            lat;     // cycle index (setup cycle = 1) in which pready is high
      logic [DW-1:0] prdata;
      logic          slverr;
      logic [AW-1:0] addr;
      logic          wr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] wmask;
      bit            stable;  // request fields unchanged for the whole request
      bit            clean;   // APB result back to 0 the cycle after pready
      bit            hung;    // pready never arrived
   } res_t;

   // Reference: what a transfer should look like, from the access rules alone.
   // delay = REQ cycle in which the response arrives (0 = never).
   function automatic res_t model(input logic [AW-1:0] addr, input logic wr,
                                  input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                  input int delay, input logic err, input logic [DW-1:0] rdata);
      res_t e;
      e = '{default: 0};
      e.stable = 1; e.clean = 1;
      e.addr = addr; e.wr = wr; e.wdata = wdata;
      for (int k = 0; k < int'(SW); k++) e.wmask[8*k +: 8] = (wr && strb[k]) ? 8'hFF : 8'h00;
      if ((addr % SW) != 0) begin
         e.reqc = 0; e.slverr = 1; e.prdata = 0;
      end else if (delay != 0 && delay <= int'(TMO)) begin
         e.reqc = delay; e.slverr = err; e.prdata = wr ? '0 : rdata;
      end else begin
         e.reqc = TMO; e.slverr = 1; e.prdata = 0;
      end
      e.lat = e.reqc + 2;
      return e;
   endfunction

   // Runs one APB transfer and plays the register block; returns what was observed.
   // Starts and ends 1 time unit after a rising edge so calls chain back-to-back.
   task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] strb, input int delay, input logic err,
                       input logic [DW-1:0] rdata, input bit spurious, output res_t o);
      int cyc;
      bit done;
      o = '{default: 0};
      o.stable = 1; o.clean = 1;
      bus_if.i_psel = 1; bus_if.i_penable = 0;
      bus_if.i_paddr = addr; bus_if.i_pwrite = wr; bus_if.i_pwdata = wdata; bus_if.i_pstrb = strb;
      bus_if.i_resp_valid = 0;
      cyc = 1; done = 0;
      while (!done && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         bus_if.i_penable = 1;
         bus_if.i_resp_valid = 0;
         if (bus_if.o_req_valid) begin
            o.reqc++;
            if (o.reqc == 1) begin
               o.addr = bus_if.o_req_addr; o.wr = bus_if.o_req_write;
               o.wdata = bus_if.o_req_wdata; o.wmask = bus_if.o_req_wmask;
            end else if (o.addr !== bus_if.o_req_addr || o.wr !== bus_if.o_req_write ||
                         o.wdata !== bus_if.o_req_wdata || o.wmask !== bus_if.o_req_wmask) begin
               o.stable = 0;
            end
            if (o.reqc == delay) begin
               bus_if.i_resp_valid = 1; bus_if.i_resp_error = err; bus_if.i_resp_rdata = rdata;
            end
         end
         if (bus_if.o_pready) begin
            o.lat = cyc; o.prdata = bus_if.o_prdata; o.slverr = bus_if.o_pslverr;
            done = 1;
            if (spurious) begin
               bus_if.i_resp_valid = 1; bus_if.i_resp_error = 1; bus_if.i_resp_rdata = '1;
            end
         end
      end
      o.hung = !done;
      @(posedge clk); #1;
      bus_if.i_psel = 0; bus_if.i_penable = 0; bus_if.i_resp_valid = 0;
      if (bus_if.o_pready !== 1'b0 || bus_if.o_prdata !== '0 || bus_if.o_pslverr !== 1'b0 ||
          bus_if.o_req_valid !== 1'b0) o.clean = 0;
   endtask

   task automatic test_reset();
      logic [115:0] outs;
      rst = 1;
      bus_if.i_psel = 0; bus_if.i_penable = 0; bus_if.i_paddr = '0; bus_if.i_pwrite = 0;
      bus_if.i_pwdata = '0; bus_if.i_pstrb = '0;
      bus_if.i_resp_valid = 0; bus_if.i_resp_error = 0; bus_if.i_resp_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      outs = {bus_if.o_pready, bus_if.o_prdata, bus_if.o_pslverr, bus_if.o_req_valid,
              bus_if.o_req_write, bus_if.o_req_addr, bus_if.o_req_wdata, bus_if.o_req_wmask};
      tests_run++;
      if (outs !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h, want 0", outs);
      end
      rst = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_basic();
      res_t o;
      xfer(16'h0010, 1, 32'hA5A5_1234, 4'b0011, 1, 0, 32'h0, 0, o);
      tests_run++;
      if (o.wmask !== 32'h0000_FFFF) begin tests_failed++; $display("FAIL wr_wmask: got %h, want 0000ffff", o.wmask); end
      tests_run++;
      if (o.wdata !== 32'hA5A5_1234 || o.wr !== 1'b1 || o.addr !== 16'h0010) begin
         tests_failed++; $display("FAIL wr_fields: got addr %h wr %b wdata %h, want 0010 1 a5a51234", o.addr, o.wr, o.wdata);
      end
      tests_run++;
      if (o.lat !== 3) begin tests_failed++; $display("FAIL wr_latency: got %0d, want 3", o.lat); end
      tests_run++;
      if (o.slverr !== 1'b0 || o.reqc !== 1) begin tests_failed++; $display("FAIL wr_result: got slverr %b reqc %0d, want 0 1", o.slverr, o.reqc); end
      tests_run++;
      if (o.clean !== 1'b1) begin tests_failed++; $display("FAIL wr_pready_width: got clean %b, want 1", o.clean); end
   endtask

   task automatic test_read_delayed();
      res_t o;
      xfer(16'h0004, 0, 32'h1111_2222, 4'hF, 5, 0, 32'hDEAD_BEEF, 0, o);
      tests_run++;
      if (o.wmask !== '0 || o.wr !== 1'b0) begin tests_failed++; $display("FAIL rd_wmask: got wmask %h wr %b, want 0 0", o.wmask, o.wr); end
      tests_run++;
      if (o.reqc !== 5 || o.stable !== 1'b1) begin tests_failed++; $display("FAIL rd_req_cycles: got %0d stable %b, want 5 1", o.reqc, o.stable); end
      tests_run++;
      if (o.prdata !== 32'hDEAD_BEEF || o.slverr !== 1'b0) begin
         tests_failed++; $display("FAIL rd_data: got %h slverr %b, want deadbeef 0", o.prdata, o.slverr);
      end
      tests_run++;
      if (o.lat !== 7) begin tests_failed++; $display("FAIL rd_latency: got %0d, want 7", o.lat); end
   endtask

   task automatic test_misaligned();
      res_t o;
      xfer(16'h0002, 0, 32'h0, 4'hF, 1, 0, 32'h5555_5555, 0, o);
      tests_run++;
      if (o.reqc !== 0) begin tests_failed++; $display("FAIL mis_no_req: got %0d req cycles, want 0", o.reqc); end
      tests_run++;
      if (o.lat !== 2) begin tests_failed++; $display("FAIL mis_latency: got %0d, want 2", o.lat); end
      tests_run++;
      if (o.slverr !== 1'b1 || o.prdata !== '0) begin tests_failed++; $display("FAIL mis_result: got slverr %b prdata %h, want 1 0", o.slverr, o.prdata); end
   endtask

   task automatic test_timeout();
      res_t o;
      xfer(16'h0100, 0, 32'h0, 4'hF, 0, 0, 32'h0, 0, o);
      tests_run++;
      if (o.reqc !== 8 || o.lat !== 10) begin tests_failed++; $display("FAIL tmo_cycles: got reqc %0d lat %0d, want 8 10", o.reqc, o.lat); end
      tests_run++;
      if (o.slverr !== 1'b1 || o.prdata !== '0) begin tests_failed++; $display("FAIL tmo_result: got slverr %b prdata %h, want 1 0", o.slverr, o.prdata); end
      xfer(16'h0104, 0, 32'h0, 4'hF, 8, 0, 32'h1234_5678, 0, o);
      tests_run++;
      if (o.reqc !== 8 || o.lat !== 10) begin tests_failed++; $display("FAIL tmo_edge_cycles: got reqc %0d lat %0d, want 8 10", o.reqc, o.lat); end
      tests_run++;
      if (o.slverr !== 1'b0 || o.prdata !== 32'h1234_5678) begin
         tests_failed++; $display("FAIL tmo_edge_result: got slverr %b prdata %h, want 0 12345678", o.slverr, o.prdata);
      end
   endtask

   task automatic test_error_carryover();
      res_t o;
      xfer(16'h0020, 1, 32'hFFFF_0000, 4'hF, 2, 1, 32'h0, 0, o);
      tests_run++;
      if (o.slverr !== 1'b1 || o.prdata !== '0) begin tests_failed++; $display("FAIL err_write: got slverr %b prdata %h, want 1 0", o.slverr, o.prdata); end
      xfer(16'h0008, 0, 32'h0, 4'hF, 1, 0, 32'hCAFE_F00D, 0, o);
      tests_run++;
      if (o.slverr !== 1'b0 || o.prdata !== 32'hCAFE_F00D) begin
         tests_failed++; $display("FAIL err_carryover: got slverr %b prdata %h, want 0 cafef00d", o.slverr, o.prdata);
      end
   endtask

   task automatic test_reset_mid();
      res_t o;
      logic [115:0] outs;
      bus_if.i_psel = 1; bus_if.i_penable = 0; bus_if.i_paddr = 16'h000C; bus_if.i_pwrite = 0;
      bus_if.i_resp_valid = 0;
      @(posedge clk); #1;
      bus_if.i_penable = 1;
      tests_run++;
      if (bus_if.o_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_req: got req_valid %b, want 1", bus_if.o_req_valid); end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      outs = {bus_if.o_pready, bus_if.o_prdata, bus_if.o_pslverr, bus_if.o_req_valid,
              bus_if.o_req_write, bus_if.o_req_addr, bus_if.o_req_wdata, bus_if.o_req_wmask};
      tests_run++;
      if (outs !== '0) begin tests_failed++; $display("FAIL rstmid_outputs: got %h, want 0", outs); end
      bus_if.i_psel = 0; bus_if.i_penable = 0;
      @(posedge clk); #1;
      tests_run++;
      if (bus_if.o_req_valid !== 1'b0 || bus_if.o_pready !== 1'b0) begin
         tests_failed++; $display("FAIL rstmid_idle: got req_valid %b pready %b, want 0 0", bus_if.o_req_valid, bus_if.o_pready);
      end
      xfer(16'h000C, 0, 32'h0, 4'hF, 3, 0, 32'h0BAD_F00D, 0, o);
      tests_run++;
      if (o.prdata !== 32'h0BAD_F00D || o.slverr !== 1'b0 || o.lat !== 5) begin
         tests_failed++; $display("FAIL rstmid_follow: got prdata %h slverr %b lat %0d, want 0badf00d 0 5", o.prdata, o.slverr, o.lat);
      end
   endtask

   // Back-to-back random transfers, including misaligned, timed-out and spurious responses
   task automatic test_back_to_back();
      res_t o, e;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, rdata;
      logic [SW-1:0] strb;
      logic wr, err;
      int delay;
      bit spur;
      for (int n = 0; n < 150; n++) begin
         addr = AW'($urandom);
         if ($urandom_range(3) != 0) addr[1:0] = 2'b00;
         wr = 1'($urandom); wdata = $urandom; rdata = $urandom; strb = SW'($urandom);
         err = ($urandom_range(4) == 0); delay = $urandom_range(0, 10); spur = 1'($urandom);
         e = model(addr, wr, wdata, strb, delay, err, rdata);
         xfer(addr, wr, wdata, strb, delay, err, rdata, spur, o);
         tests_run++;
         if (o.hung || o.lat !== e.lat || o.reqc !== e.reqc) begin
            tests_failed++;
            $display("FAIL b2b_timing[%0d]: got hung %b lat %0d reqc %0d, want 0 %0d %0d", n, o.hung, o.lat, o.reqc, e.lat, e.reqc);
         end
         tests_run++;
         if (o.prdata !== e.prdata || o.slverr !== e.slverr || o.clean !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_result[%0d]: got prdata %h slverr %b clean %b, want %h %b 1", n, o.prdata, o.slverr, o.clean, e.prdata, e.slverr);
         end
         if (e.reqc > 0) begin
            tests_run++;
            if (o.addr !== e.addr || o.wr !== e.wr || o.wdata !== e.wdata || o.wmask !== e.wmask || o.stable !== 1'b1) begin
               tests_failed++;
               $display("FAIL b2b_req[%0d]: got %h %b %h %h stable %b, want %h %b %h %h 1", n, o.addr, o.wr, o.wdata, o.wmask, o.stable, e.addr, e.wr, e.wdata, e.wmask);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_delayed();
      test_misaligned();
      test_timeout();
      test_error_carryover();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
